red_pitaya_fads_sort_sched: RTL

- Time-stamped sort-pulse scheduler between the FADS droplet classifier and the sort actuator output.
- Queues classifier "sort" decisions with their due times, so new droplets keep being classified while earlier sorts are still pending.
- Replays each queued decision as one sort_trig pulse after a programmable delay.
- Enforces pulse duration and a minimum holdoff between pulses, and counts fired, dropped and late events for the system-bus register file.

---
 rtl/red_pitaya_fads_sort_sched.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/red_pitaya_fads_sort_sched.sv
// FADS sort-pulse scheduler: queues time-stamped sort decisions and replays them as pulses.
// Optional FADS_SORT_MERGE_EN: due events during a pulse extend it instead of waiting.
module red_pitaya_fads_sort_sched #(
    parameter int QAW = 3,
    parameter int TW  = 32
) (
    input  logic          adc_clk_i,
    input  logic          adc_rstn_i,
    input  logic          enable_i,
    input  logic          flush_i,
    input  logic          req_i,
    input  logic [TW-1:0] cfg_delay_i,
    input  logic [TW-1:0] cfg_duration_i,
    input  logic [TW-1:0] cfg_holdoff_i,
    output logic          sort_trig_o,
    output logic          busy_o,
    output logic [QAW:0]  pending_o,
    output logic [TW-1:0] fired_cnt_o,
    output logic [TW-1:0] drop_cnt_o,
    output logic [TW-1:0] late_cnt_o
);
    localparam int DEPTH = 1 << QAW;
    localparam logic [TW-1:0] MAXD = {1'b0, {(TW-1){1'b1}}};

    typedef enum logic [1:0] {IDLE, WAIT, PULSE, HOLD} state_t;

    state_t         state_q, state_d;
    logic [TW-1:0]  ts_q;
    logic [TW-1:0]  mem_q [DEPTH];
    logic [QAW-1:0] wr_q, rd_q;
    logic [QAW:0]   cnt_q, cnt_d;
    logic           due_q, late_q;
    logic [TW-1:0]  dur_q, dur_d, hold_q, hold_d;
    logic           trig_q, trig_d, busy_q;
    logic [TW-1:0]  fired_q, drop_q, late_cnt_q;

    logic           acc, push, drop, pop, fire, late_inc, end_p;
    logic           ne_keep, ne_pop;
    logic [TW-1:0]  dly, head, diff;

    assign acc     = req_i && enable_i && !flush_i;
    assign push    = acc && !cnt_q[QAW];
    assign drop    = acc && cnt_q[QAW];
    assign dly     = (cfg_delay_i > MAXD) ? MAXD : cfg_delay_i;
    assign head    = mem_q[rd_q];
    assign diff    = ts_q - head;
    assign ne_keep = (cnt_q != '0) || push;
    assign ne_pop  = (cnt_q[QAW:1] != '0) || push;

    always_comb begin
        state_d  = state_q;
        dur_d    = dur_q;
        hold_d   = hold_q;
        trig_d   = trig_q;
        pop      = 1'b0;
        fire     = 1'b0;
        late_inc = 1'b0;
        end_p    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (push) state_d = WAIT;
            end
            WAIT: begin
                if (due_q) begin
                    pop      = 1'b1;
                    fire     = 1'b1;
                    late_inc = late_q;
                    if (cfg_duration_i != '0) begin
                        dur_d   = cfg_duration_i;
                        trig_d  = 1'b1;
                        state_d = PULSE;
                    end else begin
                        state_d = ne_pop ? WAIT : IDLE;
                    end
                end
            end
            PULSE: begin
                if (dur_q > TW'(1)) dur_d = dur_q - 1'b1;
                else end_p = 1'b1;
`ifdef FADS_SORT_MERGE_EN
                if (due_q) begin
                    pop  = 1'b1;
                    fire = 1'b1;
                    if (cfg_duration_i != '0) begin
                        dur_d = cfg_duration_i;
                        end_p = 1'b0;
                    end
                end
`endif
                if (end_p) begin
                    trig_d = 1'b0;
                    // holdoff of 0 or 1 is covered by the single WAIT cycle
                    if (cfg_holdoff_i > TW'(1)) begin
                        hold_d  = cfg_holdoff_i;
                        state_d = HOLD;
                    end else begin
                        state_d = (pop ? ne_pop : ne_keep) ? WAIT : IDLE;
                    end
                end
            end
            HOLD: begin
                if (hold_q > TW'(2)) hold_d = hold_q - 1'b1;
                else state_d = ne_keep ? WAIT : IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (flush_i) begin
            state_d  = IDLE;
            trig_d   = 1'b0;
            pop      = 1'b0;
            fire     = 1'b0;
            late_inc = 1'b0;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (flush_i) cnt_d = '0;
        else if (push && !pop) cnt_d = cnt_q + 1'b1;
        else if (pop && !push) cnt_d = cnt_q - 1'b1;
    end

    // due = accept-edge ts + 1 + delay, so the registered compare adds the second cycle
    always_ff @(posedge adc_clk_i) begin
        if (push) mem_q[wr_q] <= ts_q + dly + 1'b1;
    end

    always_ff @(posedge adc_clk_i or negedge adc_rstn_i) begin
        if (!adc_rstn_i) begin
            state_q    <= IDLE;
            ts_q       <= '0;
            wr_q       <= '0;
            rd_q       <= '0;
            cnt_q      <= '0;
            due_q      <= 1'b0;
            late_q     <= 1'b0;
            dur_q      <= '0;
            hold_q     <= '0;
            trig_q     <= 1'b0;
            busy_q     <= 1'b0;
            fired_q    <= '0;
            drop_q     <= '0;
            late_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            ts_q    <= ts_q + 1'b1;
            dur_q   <= dur_d;
            hold_q  <= hold_d;
            trig_q  <= trig_d;
            cnt_q   <= cnt_d;
            busy_q  <= (state_d != IDLE) || (cnt_d != '0);
            if (flush_i) begin
                wr_q <= '0;
                rd_q <= '0;
            end else begin
                if (push) wr_q <= wr_q + 1'b1;
                if (pop) rd_q <= rd_q + 1'b1;
            end
            if (flush_i || pop || cnt_q == '0) begin
                due_q  <= 1'b0;
                late_q <= 1'b0;
            end else begin
                due_q  <= !diff[TW-1];
                late_q <= !diff[TW-1] && (diff != '0);
            end
            if (fire) fired_q <= fired_q + 1'b1;
            if (late_inc) late_cnt_q <= late_cnt_q + 1'b1;
            if (drop && drop_q != '1) drop_q <= drop_q + 1'b1;
        end
    end

    assign sort_trig_o = trig_q;
    assign busy_o      = busy_q;
    assign pending_o   = cnt_q;
    assign fired_cnt_o = fired_q;
    assign drop_cnt_o  = drop_q;
    assign late_cnt_o  = late_cnt_q;

endmodule
